// File: rtl/wb_mst_ctrl_if.sv
// Wishbone classic bus between wb_mst_ctrl and a single slave.
interface wb_mst_ctrl_if;
    logic [31:0] adr;
    logic [31:0] dout;
    logic [31:0] din;
    logic [3:0]  sel;
    logic        cyc;
    logic        stb;
    logic        we;
    logic        ack;
    logic        err;
    logic        rty;

    modport master (
        output adr, dout, sel, cyc, stb, we,
        input  din, ack, err, rty
    );

    modport slave (
        input  adr, dout, sel, cyc, stb, we,
        output din, ack, err, rty
    );
endinterface

// File: rtl/wb_mst_ctrl.sv
// Wishbone burst master: runs one read or write burst per command, with
// per-word retry, bus error abort and no-response timeout.
module wb_mst_ctrl #(
    parameter int unsigned TO_CYC  = 255,
    parameter int unsigned MAX_RTY = 3,
    parameter int unsigned RTY_GAP = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_we,
    input  logic [31:0] cmd_adr,
    input  logic [3:0]  cmd_sel,
    input  logic [3:0]  cmd_len,
    input  logic [31:0] wd_dat,
    output logic        wd_next,
    output logic        rsp_valid,
    output logic [31:0] rsp_dat,
    output logic        done,
    output logic [1:0]  status,
    output logic [4:0]  wcnt,
    wb_mst_ctrl_if.master wb
);

    localparam int unsigned TO_W     = 10;
    localparam int unsigned RTY_W    = $clog2(MAX_RTY + 1) + 1;
    localparam int unsigned GAP_W    = $clog2(RTY_GAP + 1) + 1;
    localparam int unsigned GAP_LAST = (RTY_GAP > 0) ? RTY_GAP - 1 : 0;

    localparam logic [1:0] ST_OK  = 2'b00;
    localparam logic [1:0] ST_ERR = 2'b01;
    localparam logic [1:0] ST_RTY = 2'b10;
    localparam logic [1:0] ST_TO  = 2'b11;

    typedef enum logic [1:0] {IDLE, BUS, GAP, DONE} state_t;

    state_t             state;
    logic [31:0]        adr_q;
    logic               cyc_q;
    logic               we_q;
    logic [3:0]         sel_q;
    logic [3:0]         len_q;
    logic [TO_W-1:0]    to_cnt;
    logic [RTY_W-1:0]   rty_cnt;
    logic [GAP_W-1:0]   gap_cnt;

    // cyc and stb always move together for this single-slave master
    assign wb.adr  = adr_q;
    assign wb.cyc  = cyc_q;
    assign wb.stb  = cyc_q;
    assign wb.we   = we_q;
    assign wb.sel  = sel_q;
    // write data follows the producer so back-to-back acks see the next word
    assign wb.dout = (cyc_q && we_q) ? wd_dat : 32'd0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            adr_q     <= 32'd0;
            cyc_q     <= 1'b0;
            we_q      <= 1'b0;
            sel_q     <= 4'd0;
            len_q     <= 4'd0;
            to_cnt    <= '0;
            rty_cnt   <= '0;
            gap_cnt   <= '0;
            cmd_ready <= 1'b0;
            wd_next   <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_dat   <= 32'd0;
            done      <= 1'b0;
            status    <= ST_OK;
            wcnt      <= 5'd0;
        end else begin
            wd_next   <= 1'b0;
            rsp_valid <= 1'b0;
            done      <= 1'b0;

            case (state)
                IDLE: begin
                    cmd_ready <= 1'b1;
                    if (cmd_valid && cmd_ready) begin
                        cmd_ready <= 1'b0;
                        we_q      <= cmd_we;
                        adr_q     <= cmd_adr;
                        sel_q     <= cmd_sel;
                        len_q     <= cmd_len;
                        wcnt      <= 5'd0;
                        status    <= ST_OK;
                        rty_cnt   <= '0;
                        to_cnt    <= '0;
                        cyc_q     <= 1'b1;
                        state     <= BUS;
                    end
                end

                BUS: begin
                    if (cyc_q && wb.err) begin
                        cyc_q  <= 1'b0;
                        status <= ST_ERR;
                        done   <= 1'b1;
                        state  <= DONE;
                    end else if (cyc_q && wb.rty) begin
                        to_cnt <= '0;
                        cyc_q  <= 1'b0;
                        if (rty_cnt == RTY_W'(MAX_RTY)) begin
                            status <= ST_RTY;
                            done   <= 1'b1;
                            state  <= DONE;
                        end else begin
                            rty_cnt <= rty_cnt + RTY_W'(1);
                            gap_cnt <= '0;
                            state   <= GAP;
                        end
                    end else if (cyc_q && wb.ack) begin
                        adr_q   <= adr_q + 32'd4;
                        wcnt    <= wcnt + 5'd1;
                        rty_cnt <= '0;
                        to_cnt  <= '0;
                        if (we_q) begin
                            wd_next <= 1'b1;
                        end else begin
                            rsp_valid <= 1'b1;
                            rsp_dat   <= wb.din;
                        end
                        if (wcnt == {1'b0, len_q}) begin
                            cyc_q  <= 1'b0;
                            status <= ST_OK;
                            done   <= 1'b1;
                            state  <= DONE;
                        end
                    end else if (to_cnt == TO_W'(TO_CYC - 1)) begin
                        cyc_q  <= 1'b0;
                        status <= ST_TO;
                        done   <= 1'b1;
                        state  <= DONE;
                    end else begin
                        to_cnt <= to_cnt + TO_W'(1);
                    end
                end

                // bus released between a retry and its reissue
                GAP: begin
                    if (gap_cnt == GAP_W'(GAP_LAST)) begin
                        cyc_q <= 1'b1;
                        state <= BUS;
                    end else begin
                        gap_cnt <= gap_cnt + GAP_W'(1);
                    end
                end

                DONE: begin
                    cmd_ready <= 1'b1;
                    state     <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/wb_mst_ctrl.md
WB_MST_CTRL -- requirements
Module: wb_mst_ctrl

Interface
REQ-001 The block SHALL have parameter TO_CYC, default 255, meaning cycles without ack/err/rty before timeout (1..1023).
REQ-002 The block SHALL have parameter MAX_RTY, default 3, meaning retries allowed per word before abort.
REQ-003 The block SHALL have parameter RTY_GAP, default 2, meaning idle cycles with cyc=0 between a rty and the reissue.
REQ-004 clk  in  1  single clock; all state updates on the rising edge.
REQ-005 rst  in  1  asynchronous, active-low reset.
REQ-006 cmd_valid  in  1 / cmd_ready  out  1: command handshake; transfer occurs when both are high at a clk edge.
REQ-007 cmd_we  in  1 (1=write), cmd_adr  in  32 (word-aligned start address), cmd_sel  in  4 (byte lanes), cmd_len  in  4 (word count minus 1).
REQ-008 wd_dat  in  32  write data for the current word; wd_next  out  1  one-cycle pulse when the current write word is acked.
REQ-009 rsp_valid  out  1 / rsp_dat  out  32: read data for one acked read word; no backpressure.
REQ-010 done  out  1  one-cycle completion pulse; status  out  2  (00 ok, 01 err, 10 retry exhausted, 11 timeout); wcnt  out  5  words completed.
REQ-011 adr  out  32, dout  out  32, cyc  out  1, stb  out  1, sel  out  4, we  out  1: Wishbone master outputs.
REQ-012 din  in  32, ack  in  1, err  in  1, rty  in  1: Wishbone slave responses.

Function
REQ-013 FSM states SHALL be IDLE, BUS, GAP, DONE.
REQ-014 cmd_ready SHALL be 1 only in IDLE.
REQ-015 On command accept, the block SHALL latch we, adr, sel and len, clear word/retry/timeout counters, and enter BUS on the next cycle.
REQ-016 In BUS, cyc and stb SHALL be 1, we/sel SHALL be the latched values, and dout SHALL equal wd_dat when we=1 (0 otherwise).
REQ-017 Responses SHALL be sampled at the clk edge while stb=1, with priority err > rty > ack.
REQ-018 On ack: adr += 4 (32-bit wrap, 0xFFFFFFFC -> 0x0), wcnt += 1, retry counter cleared, timeout counter cleared.
REQ-019 On ack, read: rsp_valid=1 and rsp_dat=din for one cycle. Write: wd_next=1 for one cycle.
REQ-020 After the ack of word len+1, the block SHALL deassert cyc/stb next cycle and enter DONE with status 00.
REQ-021 Before the last word, cyc and stb SHALL stay 1 continuously; back-to-back acks are legal, one word per cycle.
REQ-022 On err: deassert cyc/stb next cycle; DONE with status 01; wcnt excludes the errored word.
REQ-023 On rty with retry count < MAX_RTY: increment retry count, deassert cyc/stb, enter GAP for RTY_GAP cycles, return to BUS with the same adr and data.
REQ-024 On rty with retry count = MAX_RTY: enter DONE with status 10.
REQ-025 The timeout counter SHALL increment each BUS cycle without a response; reaching TO_CYC enters DONE with status 11 and deasserts cyc/stb.
REQ-026 DONE SHALL last one cycle with done=1, status and wcnt valid, then return to IDLE.
REQ-027 status and wcnt SHALL hold their values until the next accepted command.
REQ-028 A response received while stb=0 SHALL be ignored.

Reset
REQ-029 While rst=0, the block SHALL force the following immediately, without waiting for a clock edge: state IDLE, cyc=stb=we=0, adr=0, dout=0, sel=0, cmd_ready=0, rsp_valid=0, rsp_dat=0, wd_next=0, done=0, status=00, wcnt=0.
REQ-030 cmd_ready SHALL rise on the first clk edge after rst=1.
REQ-031 A reset mid-burst SHALL abandon the transfer with no done pulse.

Verification
REQ-032 Single read: adr 0x100, len 0, sel F, slave ack 0-wait, mem[0x40]=0xBFBF4040 -> one rsp_valid with rsp_dat 0xBFBF4040; done with status 00 and wcnt 1.
REQ-033 Burst write: adr 0x200, len 3, wd_dat 1..4, slave ack delay 2 -> four wd_next pulses; adr 0x200, 0x204, 0x208, 0x20C; cyc high throughout; status 00 and wcnt 4; readback matches.
REQ-034 Retry: rty on the first two attempts, then ack -> cyc low for 2 cycles after each rty; same adr on reissue; status 00.
REQ-035 Retry exhausted: rty held with MAX_RTY=3 -> 4 attempts, then done with status 10 and wcnt 0.
REQ-036 Error/timeout: err on word 2 of len 3 -> status 01, wcnt 1; no response with TO_CYC=8 -> done 8 cycles after stb, status 11.
REQ-037 Async reset asserted during a burst -> cyc low before the next edge, no done pulse; after release, cmd_ready=1 and a new single read succeeds.
